// File: rtl/fir_cfg_ctrl.sv
// Coefficient-bank loader and sample/response sequencer for the FIR datapath.
// Loads a bank from synchronous ROM, clears the delay line, then gates samples and masks warm-up responses.
module fir_cfg_ctrl #(
  parameter int NUM_TAPS    = 51,
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_BANKS   = 4,
  parameter int FIR_LAT     = 1,
  localparam int BANK_W     = $clog2(NUM_BANKS),
  localparam int IDX_W      = $clog2(NUM_TAPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_req,
  input  logic [BANK_W-1:0]      bank_sel,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  output logic [BANK_W-1:0]      active_bank,
  output logic [7:0]             rom_addr,
  input  logic [COEFF_WIDTH-1:0] rom_data,
  output logic                   coef_we,
  output logic [IDX_W-1:0]       coef_idx,
  output logic [COEFF_WIDTH-1:0] coef_data,
  input  logic [15:0]            x_in,
  input  logic                   x_valid,
  output logic [15:0]            fir_x,
  output logic                   fir_en,
  output logic                   fir_clr,
  input  logic [37:0]            y_in,
  output logic [37:0]            y_out,
  output logic                   y_valid,
  output logic                   drop,
  output logic [1:0]             dbg_state
);

  // Handshake: cfg_req and x_valid are single-cycle strobes sampled on the
  // rising edge; there is no back-pressure. coef_we, cfg_done, fir_clr and
  // y_valid are single-cycle strobes qualifying their data in the same cycle.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TAPS - 1);
  localparam logic [IDX_W-1:0] SUPP_LAST = IDX_W'(NUM_TAPS - 2);

  state_t                  state_q, state_d;
  logic                    cfg_busy_q, cfg_busy_d;
  logic                    cfg_done_q, cfg_done_d;
  logic [BANK_W-1:0]       active_bank_q, active_bank_d;
  logic [7:0]              rom_addr_q, rom_addr_d;
  logic                    addr_act_q, addr_act_d;
  logic [IDX_W-1:0]        k_q, k_d;
  logic                    coef_we_q, coef_we_d;
  logic [IDX_W-1:0]        coef_idx_q, coef_idx_d;
  logic                    pend_q, pend_d;
  logic [BANK_W-1:0]       pend_bank_q, pend_bank_d;
  logic [15:0]             fir_x_q, fir_x_d;
  logic                    fir_en_q, fir_en_d;
  logic                    fir_clr_q, fir_clr_d;
  logic [FIR_LAT:0]        pipe_q, pipe_d;
  logic [IDX_W-1:0]        supp_q, supp_d;
  logic [37:0]             y_out_q, y_out_d;
  logic                    y_valid_q, y_valid_d;
  logic                    drop_q, drop_d;
  logic                    resp;
  logic [BANK_W-1:0]       restart_bank;

  function automatic logic [7:0] bank_base(input logic [BANK_W-1:0] b);
    return 8'(b) * 8'(NUM_TAPS);
  endfunction

  // The last pipe stage lines up with the cycle in which y_in is valid.
  assign resp         = pipe_q[FIR_LAT];
  assign restart_bank = cfg_req ? bank_sel : pend_bank_q;

  always_comb begin
    state_d       = state_q;
    cfg_done_d    = 1'b0;
    active_bank_d = active_bank_q;
    rom_addr_d    = rom_addr_q;
    addr_act_d    = addr_act_q;
    k_d           = k_q;
    coef_we_d     = 1'b0;
    coef_idx_d    = coef_idx_q;
    pend_d        = pend_q;
    pend_bank_d   = pend_bank_q;
    fir_x_d       = fir_x_q;
    fir_en_d      = 1'b0;
    fir_clr_d     = 1'b0;
    supp_d        = supp_q;
    y_out_d       = y_out_q;
    y_valid_d     = 1'b0;
    drop_d        = drop_q;
    pipe_d        = '0;
    pipe_d[0]     = fir_en_q;
    for (int i = 1; i <= FIR_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_req) begin
          state_d       = ST_LOAD;
          active_bank_d = bank_sel;
          rom_addr_d    = bank_base(bank_sel);
          addr_act_d    = 1'b1;
          k_d           = '0;
          drop_d        = 1'b0;
        end else if (x_valid) begin
          drop_d = 1'b1;
        end
      end

      ST_LOAD: begin
        pipe_d = '0;
        if (x_valid) begin
          drop_d = 1'b1;
        end
        if (cfg_req) begin
          pend_d      = 1'b1;
          pend_bank_d = bank_sel;
        end
        if (addr_act_q) begin
          // ROM data for the address issued last cycle is on rom_data now.
          coef_we_d  = 1'b1;
          coef_idx_d = k_q;
          if (k_q == LAST_IDX) begin
            addr_act_d = 1'b0;
          end else begin
            k_d        = k_q + IDX_W'(1);
            rom_addr_d = rom_addr_q + 8'd1;
          end
        end else begin
          cfg_done_d = 1'b1;
          if (pend_q || cfg_req) begin
            active_bank_d = restart_bank;
            rom_addr_d    = bank_base(restart_bank);
            addr_act_d    = 1'b1;
            k_d           = '0;
            pend_d        = 1'b0;
          end else begin
            state_d   = ST_FLUSH;
            fir_clr_d = 1'b1;
            supp_d    = '0;
          end
        end
      end

      ST_FLUSH, ST_RUN: begin
        if (cfg_req) begin
          // Abort: in-flight responses are dropped via the cleared pipe.
          state_d       = ST_LOAD;
          active_bank_d = bank_sel;
          rom_addr_d    = bank_base(bank_sel);
          addr_act_d    = 1'b1;
          k_d           = '0;
          pend_d        = 1'b0;
          drop_d        = 1'b0;
          pipe_d        = '0;
        end else begin
          if (x_valid) begin
            fir_x_d  = x_in;
            fir_en_d = 1'b1;
          end
          if (resp) begin
            if (state_q == ST_RUN) begin
              y_out_d   = y_in;
              y_valid_d = 1'b1;
            end else if (supp_q == SUPP_LAST) begin
              state_d = ST_RUN;
            end else begin
              supp_d = supp_q + IDX_W'(1);
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cfg_busy_d = (state_d == ST_LOAD) || (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cfg_busy_q    <= 1'b0;
      cfg_done_q    <= 1'b0;
      active_bank_q <= '0;
      rom_addr_q    <= '0;
      addr_act_q    <= 1'b0;
      k_q           <= '0;
      coef_we_q     <= 1'b0;
      coef_idx_q    <= '0;
      pend_q        <= 1'b0;
      pend_bank_q   <= '0;
      fir_x_q       <= '0;
      fir_en_q      <= 1'b0;
      fir_clr_q     <= 1'b0;
      pipe_q        <= '0;
      supp_q        <= '0;
      y_out_q       <= '0;
      y_valid_q     <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_busy_q    <= cfg_busy_d;
      cfg_done_q    <= cfg_done_d;
      active_bank_q <= active_bank_d;
      rom_addr_q    <= rom_addr_d;
      addr_act_q    <= addr_act_d;
      k_q           <= k_d;
      coef_we_q     <= coef_we_d;
      coef_idx_q    <= coef_idx_d;
      pend_q        <= pend_d;
      pend_bank_q   <= pend_bank_d;
      fir_x_q       <= fir_x_d;
      fir_en_q      <= fir_en_d;
      fir_clr_q     <= fir_clr_d;
      pipe_q        <= pipe_d;
      supp_q        <= supp_d;
      y_out_q       <= y_out_d;
      y_valid_q     <= y_valid_d;
      drop_q        <= drop_d;
    end
  end

  assign cfg_busy    = cfg_busy_q;
  assign cfg_done    = cfg_done_q;
  assign active_bank = active_bank_q;
  assign rom_addr    = rom_addr_q;
  assign coef_we     = coef_we_q;
  assign coef_idx    = coef_idx_q;
  assign coef_data   = coef_we_q ? rom_data : '0;
  assign fir_x       = fir_x_q;
  assign fir_en      = fir_en_q;
  assign fir_clr     = fir_clr_q;
  assign y_out       = y_out_q;
  assign y_valid     = y_valid_q;
  assign drop        = drop_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// Directed bench for fir_cfg_ctrl with a behavioural ROM and a one-edge-latency filter stand-in.
module tb_fir_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_req = 1'b0;
  logic [1:0]  bank_sel = 2'd0;
  logic        cfg_busy, cfg_done;
  logic [1:0]  active_bank;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data = 16'd0;
  logic        coef_we;
  logic [5:0]  coef_idx;
  logic [15:0] coef_data;
  logic [15:0] x_in = 16'd0;
  logic        x_valid = 1'b0;
  logic [15:0] fir_x;
  logic        fir_en, fir_clr;
  logic [37:0] y_in = 38'd0;
  logic [37:0] y_out;
  logic        y_valid, drop;
  logic [1:0]  dbg_state;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_we = 0;
  int n_yv = 0;
  int snap;
  logic [37:0] exp_q[$];
  int          exp_t_q[$];
  logic [37:0] e;
  int          et;
  logic [37:0] y_in_prev = 38'd0;
  logic [15:0] cap = 16'd0;

  fir_cfg_ctrl dut (
    .clk(clk), .rst(rst), .cfg_req(cfg_req), .bank_sel(bank_sel),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .active_bank(active_bank),
    .rom_addr(rom_addr), .rom_data(rom_data), .coef_we(coef_we),
    .coef_idx(coef_idx), .coef_data(coef_data), .x_in(x_in), .x_valid(x_valid),
    .fir_x(fir_x), .fir_en(fir_en), .fir_clr(fir_clr), .y_in(y_in),
    .y_out(y_out), .y_valid(y_valid), .drop(drop), .dbg_state(dbg_state)
  );

  // ---------------- clock / models ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] rom_fn(input logic [7:0] a);
    return {a ^ 8'hA5, a};
  endfunction

  function automatic logic [37:0] y_fn(input logic [15:0] x);
    return {{22{x[15]}}, x} * 38'd7 + 38'd5;
  endfunction

  function automatic logic [15:0] sine_x(input int n);
    real r;
    r = 10000.0 * $sin(2.0 * 3.14159265358979 * n / 25.0);
    return 16'($rtoi(r));
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  always @(posedge clk) begin
    if (fir_clr) cap <= 16'd0;
    else if (fir_en) cap <= fir_x;
    y_in <= y_fn(cap);
  end

  // ---------------- check / driver tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [15:0] x, input bit expect_out);
    x_in = x;
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    if (expect_out) begin
      exp_q.push_back(y_fn(x));
      exp_t_q.push_back(cyc);
    end
    chk("fir_en_after_x", fir_en, 1);
    chk("fir_x_after_x", fir_x, x);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && !cfg_done; i++) tick();
    chk("cfg_done_timeout", cfg_done, 1);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst && y_valid) begin
      n_yv++;
      chk("y_valid_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        et = exp_t_q.pop_front();
        chk("y_out", y_out, e);
        chk("y_latency", cyc - et, 3);
        chk("y_out_vs_prev_y_in", y_out, y_in_prev);
      end
    end
    if (coef_we) n_we++;
    y_in_prev = y_in;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_cfg_busy", cfg_busy, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_active_bank", active_bank, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_coef_we", coef_we, 0);
    chk("rst_coef_data", coef_data, 0);
    chk("rst_fir_en", fir_en, 0);
    chk("rst_fir_clr", fir_clr, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_drop", drop, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b1;
    tick();

    // IDLE: samples are dropped
    x_in = 16'h1234; x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    chk("idle_fir_en", fir_en, 0);
    chk("idle_fir_x", fir_x, 0);
    chk("idle_drop", drop, 1);
    repeat (2) tick();
    chk("idle_drop_sticky", drop, 1);

    // Load bank 3, cycle by cycle
    cfg_req = 1'b1; bank_sel = 2'd3;
    tick();
    cfg_req = 1'b0; bank_sel = 2'd0;
    chk("ld3_drop_cleared", drop, 0);
    chk("ld3_active_bank", active_bank, 3);
    chk("ld3_busy", cfg_busy, 1);
    for (int c = 1; c <= 53; c++) begin
      if (c <= 51) chk("ld3_rom_addr", rom_addr, 153 + c - 1);
      chk("ld3_coef_we", coef_we, (c >= 2) && (c <= 52));
      if (c >= 2 && c <= 52) begin
        chk("ld3_coef_idx", coef_idx, c - 2);
        chk("ld3_coef_data", coef_data, rom_fn(8'(153 + c - 2)));
      end
      chk("ld3_cfg_done", cfg_done, c == 53);
      chk("ld3_fir_clr", fir_clr, c == 53);
      if (c < 53) tick();
    end
    chk("ld3_flush_busy", cfg_busy, 1);
    chk("ld3_flush_state", dbg_state, 2);
    repeat (5) tick();
    chk("flush_clr_pulse", fir_clr, 0);
    chk("flush_done_pulse", cfg_done, 0);

    // Abort from FLUSH into a bank 2 load
    cfg_req = 1'b1; bank_sel = 2'd2;
    tick();
    cfg_req = 1'b0;
    chk("ld2_first_addr", rom_addr, 102);
    chk("ld2_state", dbg_state, 1);
    wait_done();
    chk("ld2_active_bank", active_bank, 2);
    chk("ld2_fir_clr", fir_clr, 1);

    // 60 sine samples at 1 MHz: only samples 50..59 produce outputs
    snap = n_yv;
    for (int n = 0; n < 60; n++) begin
      send_sample(sine_x(n), n >= 50);
      repeat (99) tick();
    end
    chk("sine_yv_count", n_yv - snap, 10);
    chk("sine_run_state", dbg_state, 3);

    // Abort RUN with one response in flight
    send_sample(16'h0ABC, 1'b0);
    cfg_req = 1'b1; bank_sel = 2'd1;
    tick();
    cfg_req = 1'b0;
    chk("abort_busy", cfg_busy, 1);
    chk("abort_rom_addr", rom_addr, 51);
    chk("abort_fir_en", fir_en, 0);
    snap = n_we;
    wait_done();
    chk("abort_we_count", n_we - snap, 51);
    chk("abort_active_bank", active_bank, 1);
    snap = n_yv;
    for (int n = 0; n < 50; n++) begin
      send_sample(16'(n * 300 - 7000), 1'b0);
      repeat (3) tick();
    end
    chk("warmup_no_output", n_yv - snap, 0);
    chk("warmup_state", dbg_state, 3);
    send_sample(16'h4321, 1'b1);
    repeat (4) tick();
    chk("warmup_first_output", n_yv - snap, 1);

    // cfg_req + x_valid in RUN, then a pending reload mid-LOAD
    cfg_req = 1'b1; bank_sel = 2'd2; x_valid = 1'b1; x_in = 16'h7777;
    tick();
    cfg_req = 1'b0; x_valid = 1'b0;
    chk("coinc_fir_en", fir_en, 0);
    for (int c = 1; c <= 105; c++) begin
      if (c <= 51) chk("pend_ld2_addr", rom_addr, 102 + c - 1);
      else if (c >= 53 && c <= 103) chk("pend_ld0_addr", rom_addr, c - 53);
      chk("pend_coef_we", coef_we, ((c >= 2) && (c <= 52)) || ((c >= 54) && (c <= 104)));
      if (c >= 54 && c <= 104) begin
        chk("pend_ld0_idx", coef_idx, c - 54);
        chk("pend_ld0_data", coef_data, rom_fn(8'(c - 54)));
      end
      chk("pend_cfg_done", cfg_done, (c == 53) || (c == 105));
      chk("pend_fir_clr", fir_clr, c == 105);
      chk("pend_active_bank", active_bank, (c < 53) ? 2 : 0);
      chk("pend_busy", cfg_busy, 1);
      if (c <= 52) chk("pend_drop", drop, c > 30);
      if (c == 20) begin cfg_req = 1'b1; bank_sel = 2'd0; end
      if (c == 30) begin x_valid = 1'b1; x_in = 16'h1111; end
      if (c < 105) tick();
      cfg_req = 1'b0; x_valid = 1'b0;
    end
    chk("pend_flush_state", dbg_state, 2);

    // Reset in the middle of a load
    cfg_req = 1'b1; bank_sel = 2'd1;
    tick();
    cfg_req = 1'b0;
    for (int i = 0; i < 100 && !(coef_we && coef_idx == 6'd25); i++) tick();
    chk("mid_idx25_reached", coef_idx, 25);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_coef_we", coef_we, 0);
    chk("arst_coef_idx", coef_idx, 0);
    chk("arst_coef_data", coef_data, 0);
    chk("arst_rom_addr", rom_addr, 0);
    chk("arst_busy", cfg_busy, 0);
    chk("arst_active_bank", active_bank, 0);
    chk("arst_y_out", y_out, 0);
    chk("arst_fir_x", fir_x, 0);
    chk("arst_drop", drop, 0);
    chk("arst_state", dbg_state, 0);
    repeat (3) tick();
    rst = 1'b1;
    snap = n_we;
    repeat (60) tick();
    chk("post_rst_no_we", n_we - snap, 0);
    chk("post_rst_busy", cfg_busy, 0);
    chk("post_rst_state", dbg_state, 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_cfg_ctrl.md
Name: fir_cfg_ctrl

Overview:
Configuration and sequencing controller for the 51-tap FIR filter datapath (LPF/HPF/BPF/BSF coefficient sets).
- On request, loads one coefficient bank from a synchronous coefficient ROM into the filter's coefficient register file.
- Clears the filter delay line after each load.
- Gates incoming samples into the filter.
- Suppresses filter outputs until the delay line holds a full window of post-reload samples.

Parameters:
NUM_TAPS, 51, filter taps per bank
COEFF_WIDTH, 16, coefficient width
NUM_BANKS, 4, coefficient banks in ROM (0=LPF, 1=HPF, 2=BPF, 3=BSF)
FIR_LAT, 1, clock edges from filter input capture to valid y_in

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous active-low reset
cfg_req  in  1  reload request, single-cycle pulse
bank_sel  in  2  bank to load, sampled with cfg_req
cfg_busy  out  1  high in LOAD and FLUSH
cfg_done  out  1  one-cycle pulse when LOAD completes
active_bank  out  2  bank currently loaded
rom_addr  out  8  ROM address = bank*NUM_TAPS + k
rom_data  in  16  ROM read data, one-cycle read latency
coef_we  out  1  coefficient write strobe
coef_idx  out  6  coefficient index 0..NUM_TAPS-1
coef_data  out  16  coefficient value
x_in  in  16  signed input sample
x_valid  in  1  sample strobe
fir_x  out  16  registered sample to filter
fir_en  out  1  filter clock enable (shift and accumulate)
fir_clr  out  1  one-cycle synchronous delay-line clear
y_in  in  38  signed filter output
y_out  out  38  registered filter output
y_valid  out  1  output strobe
drop  out  1  sticky: sample arrived while filter was unavailable

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0; active_bank=0. Pending flag, counters and valid pipeline cleared. Reset mid-LOAD abandons the load; no further coef_we.
- States: IDLE, LOAD, FLUSH, RUN.
- IDLE:
  - fir_en=0.
  - x_valid sets drop; the sample is discarded.
  - cfg_req -> LOAD; capture bank_sel into active_bank; clear drop.
- LOAD:
  - Address counter k=0..NUM_TAPS-1 on consecutive cycles; rom_addr=active_bank*NUM_TAPS+k.
  - One cycle later: coef_we=1, coef_idx=k, coef_data=rom_data.
  - For cfg_req accepted on edge 0: rom_addr issued in cycles 1..51; coef_we in cycles 2..52; cfg_done=1 and fir_clr=1 in cycle 53, state FLUSH.
  - x_valid during LOAD sets drop; the sample is discarded.
  - cfg_req during LOAD sets a one-deep pending flag and stores bank_sel (latest request wins).
  - At LOAD end with pending set: cfg_done still pulses, then LOAD restarts with the stored bank; fir_clr is not issued and FLUSH is skipped.
- FLUSH:
  - x_valid on edge t -> fir_x=x_in, fir_en=1 during cycle t+1; otherwise fir_en=0 and fir_x holds.
  - A delay line of FIR_LAT+1 stages tracks fir_en to identify filter responses.
  - Responses to the first NUM_TAPS-1 accepted samples are suppressed (y_valid=0).
  - After the 50th suppressed response -> RUN.
- RUN:
  - Each tracked response registers y_out<=y_in with y_valid=1.
  - x_valid-to-y_valid latency is FIR_LAT+2 cycles (3 at default).
  - y_out holds its value between strobes.
- cfg_req in FLUSH or RUN aborts immediately to LOAD with the new bank.
  - Samples still in the response pipeline are flushed: no y_valid for them.
  - drop is cleared.
- cfg_req coincident with x_valid in RUN: the sample is discarded and drop is not set.
- Counters saturate/wrap only within 0..NUM_TAPS-1.
- rom_addr width is 8 bits; max address 203.

Test Plan:
- Reset -> all outputs 0, cfg_busy=0. x_valid pulses in IDLE -> no fir_en, drop=1.
- cfg_req with bank_sel=3 on edge 0 -> rom_addr 153..203 in cycles 1..51; coef_we with coef_idx 0..50 carrying ROM contents in cycles 2..52; cfg_done and fir_clr in cycle 53; drop cleared.
- After loading bank 2, apply 60 samples at 1 MHz (x_valid every 100 clocks) from a 40 kHz sine (amplitude 10000) -> exactly 10 y_valid pulses; the first corresponds to sample 50, 3 cycles after its x_valid; y_out equals y_in one cycle prior.
- cfg_req (bank 1) mid-RUN with one response in flight -> that response not output; LOAD starts next cycle; 51 new writes occur; y_valid only after 50 new suppressed samples.
- cfg_req (bank 0) at cycle 20 of LOAD for bank 2 -> bank 2 completes with cfg_done; immediate reload of bank 0 (rom_addr 0..50); no fir_clr between the two loads; active_bank=0 at end.
- rst asserted at coef_idx=25 -> outputs zero asynchronously; no coef_we after release until the next cfg_req.
